reg_40_wr_port_arbiter: RTL and testbench

//  Shares the single write port of a 40-entry 1R/1W register file (e.g. per-wavefront

---
 rtl/reg_40_wr_port_arbiter_pkg.sv | 14 +
 rtl/reg_40_wr_port_arbiter_rr_arbiter.sv | 30 +++
 rtl/reg_40_wr_port_arbiter.sv | 116 +++++++++++
 tb/tb_reg_40_wr_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_40_wr_port_arbiter_pkg.sv
// Shared register-file geometry for the write-port arbiter slice.
// Optional read bypass is enabled by defining WRPORT_ARB_BYPASS_EN.
package reg_40_wr_port_arbiter_pkg;

    localparam int unsigned RF_NUM_ENTRIES = 40;
    localparam int unsigned RF_ADDR_W      = 6;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    function automatic logic addr_in_range(input rf_addr_t addr);
        return addr < rf_addr_t'(RF_NUM_ENTRIES);
    endfunction

endpackage

// File: rtl/reg_40_wr_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or above ptr, wrapping around,
// and reports it as a one-hot grant plus its binary index.
module reg_40_wr_port_arbiter_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    always_comb begin
        logic [IDX_W-1:0] sel;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        sel       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sel = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!gnt_valid && req[sel]) begin
                gnt_valid = 1'b1;
                gnt[sel]  = 1'b1;
                gnt_idx   = sel;
            end
        end
    end

endmodule

// File: rtl/reg_40_wr_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writers.
// Define WRPORT_ARB_BYPASS_EN to add the write-to-read forwarding path.
module reg_40_wr_port_arbiter
    import reg_40_wr_port_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [RF_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [WIDTH*NUM_REQ-1:0]     req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         wr_en,
    output logic [RF_ADDR_W-1:0]         wr_addr,
    output logic [WIDTH-1:0]             wr_data,
    output logic                         addr_err
`ifdef WRPORT_ARB_BYPASS_EN
    ,
    input  logic [RF_ADDR_W-1:0]         rd_addr,
    input  logic [WIDTH-1:0]             rd_data_rf,
    output logic [WIDTH-1:0]             rd_data
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   req_masked;
    logic [NUM_REQ-1:0]   gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_valid;
    rf_addr_t             sel_addr;
    logic [WIDTH-1:0]     sel_data;

    logic                 wr_en_q, wr_en_d;
    logic                 addr_err_q, addr_err_d;
    rf_addr_t             wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]     wr_data_q, wr_data_d;

    // Gating with rst keeps req_ready low for the whole reset window.
    assign req_masked = (rst && !stall) ? req_valid : '0;

    reg_40_wr_port_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_masked),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*RF_ADDR_W +: RF_ADDR_W];
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) begin
            ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    // Out-of-range writes are dropped at the port but still flagged.
    always_comb begin
        wr_en_d    = 1'b0;
        addr_err_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (gnt_valid) begin
            wr_en_d    = addr_in_range(sel_addr);
            addr_err_d = !addr_in_range(sel_addr);
            wr_addr_d  = sel_addr;
            wr_data_d  = sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            wr_en_q    <= 1'b0;
            addr_err_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_en_q    <= wr_en_d;
            addr_err_q <= addr_err_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign addr_err = addr_err_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

`ifdef WRPORT_ARB_BYPASS_EN
    // Forward the pending write for the cycle before the file captures it.
    assign rd_data = (wr_en_q && (wr_addr_q == rd_addr)) ? wr_data_q : rd_data_rf;
`endif

endmodule

// File: tb/tb_reg_40_wr_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a behavioural round-robin model.
module tb_reg_40_wr_port_arbiter;

    localparam int W = 4;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stall = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [6*N-1:0]  req_addr = '0;
    logic [W*N-1:0]  req_data = '0;
    logic [N-1:0]    req_ready;
    logic            wr_en;
    logic [5:0]      wr_addr;
    logic [W-1:0]    wr_data;
    logic            addr_err;
`ifdef WRPORT_ARB_BYPASS_EN
    logic [5:0]      rd_addr = '0;
    logic [W-1:0]    rd_data_rf = '0;
    logic [W-1:0]    rd_data;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    reg_40_wr_port_arbiter #(
        .WIDTH   (W),
        .NUM_REQ (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .addr_err   (addr_err)
`ifdef WRPORT_ARB_BYPASS_EN
        ,
        .rd_addr    (rd_addr),
        .rd_data_rf (rd_data_rf),
        .rd_data    (rd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_p = 0;
    int           m_last_g = -1;
    logic         m_wr_en = 1'b0;
    logic         m_err = 1'b0;
    logic [5:0]   m_addr = '0;
    logic [W-1:0] m_data = '0;

    function automatic int model_grant();
        if (!rst || stall) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_p + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst) begin
            m_p <= 0; m_last_g <= -1; m_wr_en <= 1'b0; m_err <= 1'b0;
            m_addr <= '0; m_data <= '0;
        end else begin
            g = model_grant();
            m_last_g <= g;
            if (g >= 0) begin
                m_addr  <= req_addr[g*6 +: 6];
                m_data  <= req_data[g*W +: W];
                m_wr_en <= (int'(req_addr[g*6 +: 6]) < 40);
                m_err   <= (int'(req_addr[g*6 +: 6]) >= 40);
                m_p     <= (g + 1) % N;
            end else begin
                m_wr_en <= 1'b0;
                m_err   <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] e_ready;
        g = model_grant();
        e_ready = (g >= 0) ? N'(1 << g) : '0;
        if (!rst) begin
            check("m_ready_rst", 64'(req_ready), 64'(0));
            check("m_wr_en_rst", 64'(wr_en), 64'(0));
            check("m_err_rst", 64'(addr_err), 64'(0));
            check("m_addr_rst", 64'(wr_addr), 64'(0));
            check("m_data_rst", 64'(wr_data), 64'(0));
        end else begin
            check("m_ready", 64'(req_ready), 64'(e_ready));
            check("m_wr_en", 64'(wr_en), 64'(m_wr_en));
            check("m_err", 64'(addr_err), 64'(m_err));
            check("m_addr", 64'(wr_addr), 64'(m_addr));
            check("m_data", 64'(wr_data), 64'(m_data));
`ifdef WRPORT_ARB_BYPASS_EN
            check("m_rd_data", 64'(rd_data),
                  64'((m_wr_en && m_addr == rd_addr) ? m_data : rd_data_rf));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input int a, input int d);
        req_valid[i]      = v;
        req_addr[i*6 +: 6] = 6'(a);
        req_data[i*W +: W] = W'(d);
    endtask

    initial begin
        #2 rst = 1'b0;
        req_valid = 4'b1111;
        // 1: reset holds everything low
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check("rst_err", 64'(addr_err), 64'(0));
        step();
        rst = 1'b1;

        // 2: all four requesters, addr 3+i, data i+1
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 3 + i, i + 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_ready", 64'(req_ready), 64'(1 << (k % 4)));
            if (k > 0) begin
                check("rr_wr_en", 64'(wr_en), 64'(1));
                check("rr_wr_addr", 64'(wr_addr), 64'(3 + (k - 1) % 4));
                check("rr_wr_data", 64'(wr_data), 64'(1 + (k - 1) % 4));
            end
            step();
        end
        req_valid = '0;
        @(negedge clk);
        check("rr_last_addr", 64'(wr_addr), 64'(6));
        step();

        // 3: lone req2 at addr 39, then req3 wins over req0
        set_req(2, 1'b1, 39, 1);
        @(negedge clk);
        check("r2_ready", 64'(req_ready), 64'(4'b0100));
        step();
        set_req(2, 1'b0, 0, 0);
        set_req(3, 1'b1, 12, 5);
        set_req(0, 1'b1, 13, 6);
        @(negedge clk);
        check("r2_wr_en", 64'(wr_en), 64'(1));
        check("r2_wr_addr", 64'(wr_addr), 64'(39));
        check("r2_wr_data", 64'(wr_data), 64'(1));
        check("r3_first", 64'(req_ready), 64'(4'b1000));
        step();
        req_valid = '0;
        step();

        // 4: out-of-range address
        set_req(1, 1'b1, 40, 2);
        @(negedge clk);
        check("oor_ready", 64'(req_ready), 64'(4'b0010));
        step();
        req_valid = '0;
        @(negedge clk);
        check("oor_wr_en", 64'(wr_en), 64'(0));
        check("oor_err", 64'(addr_err), 64'(1));
        step();
        @(negedge clk);
        check("oor_err_pulse", 64'(addr_err), 64'(0));
        step();

        // 5: stall freezes arbitration
        stall = 1'b1;
        set_req(0, 1'b1, 20, 3);
        set_req(1, 1'b1, 21, 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_ready", 64'(req_ready), 64'(0));
            check("stall_wr_en", 64'(wr_en), 64'(0));
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall_ready", 64'(req_ready), 64'(4'b0001));
        step();
        req_valid = '0;
        @(negedge clk);
        check("unstall_wr_addr", 64'(wr_addr), 64'(20));
        step();

`ifdef WRPORT_ARB_BYPASS_EN
        // 6: forwarding of the pending write
        set_req(0, 1'b1, 7, 1);
        step();
        req_valid  = '0;
        rd_addr    = 6'd7;
        rd_data_rf = '0;
        @(negedge clk);
        check("byp_hit", 64'(rd_data), 64'(1));
        #1;
        rd_addr    = 6'd8;
        rd_data_rf = 4'hA;
        #1;
        check("byp_miss", 64'(rd_data), 64'(4'hA));
        step();
`endif

        // randomized traffic; held requests only change once accepted
        for (int c = 0; c < 3000; c++) begin
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst = 1'b0;
            for (int i = 0; i < N; i++) begin
                int a;
                a = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 63) : $urandom_range(0, 39);
                if (req_valid[i] && m_last_g != i) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else begin
                    set_req(i, $urandom_range(0, 2) != 0, a, $urandom);
                end
            end
            stall = ($urandom_range(0, 7) == 0);
`ifdef WRPORT_ARB_BYPASS_EN
            rd_addr    = $urandom_range(0, 1) != 0 ? m_addr : 6'($urandom_range(0, 63));
            rd_data_rf = W'($urandom);
`endif
            step();
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
